// File: rtl/y_axis_downsizer.sv
// Serialises one wide AXI-Stream word (R lanes of WY bits) into AXI_WIDTH-bit
// beats, lowest slice first, carrying tlast onto the final beat of the word.
module y_axis_downsizer #(
   parameter int unsigned R         = 4,
   parameter int unsigned WY        = 32,
   parameter int unsigned AXI_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [R*WY-1:0]        s_axis_tdata,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic [AXI_WIDTH-1:0]   m_axis_tdata,
   output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   input  logic                   m_axis_tready,
   output logic [31:0]            beat_count
);

   localparam int unsigned W_IN   = R * WY;
   localparam int unsigned NBEATS = W_IN / AXI_WIDTH;
   localparam int unsigned WB     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   if ((NBEATS == 0) || ((W_IN % AXI_WIDTH) != 0)) begin : g_bad_width
      $fatal(1, "y_axis_downsizer: R*WY must be a non-zero multiple of AXI_WIDTH");
   end

   typedef enum logic {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [W_IN-1:0]   data_q, data_d;
   logic              last_q, last_d;
   logic [WB-1:0]     idx_q, idx_d;
   logic [31:0]       cnt_q, cnt_d;

   logic              at_last_c;
   logic              s_fire_c;
   logic              m_fire_c;

   assign at_last_c     = (idx_q == WB'(NBEATS - 1));
   assign m_axis_tvalid = (state_q == SEND);
   assign m_axis_tdata  = data_q[AXI_WIDTH-1:0];
   assign m_axis_tkeep  = '1;
   assign m_axis_tlast  = m_axis_tvalid & last_q & at_last_c;
   assign beat_count    = cnt_q;

   // Ready only depends on sink ready, so the upstream never sees a loop through tvalid.
   assign s_axis_tready = rstn & ((state_q == EMPTY) | (m_axis_tready & at_last_c));
   assign s_fire_c      = s_axis_tvalid & s_axis_tready;
   assign m_fire_c      = m_axis_tvalid & m_axis_tready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= EMPTY;
         data_q  <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      last_d  = last_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 32'(m_fire_c);

      case (state_q)
         EMPTY: begin
            if (s_fire_c) begin
               data_d  = s_axis_tdata;
               last_d  = s_axis_tlast;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (m_fire_c) begin
               if (!at_last_c) begin
                  data_d = W_IN'(data_q >> AXI_WIDTH);
                  idx_d  = idx_q + WB'(1);
               end else if (s_fire_c) begin
                  // Reload on the final beat so back-to-back words have no bubble.
                  data_d = s_axis_tdata;
                  last_d = s_axis_tlast;
                  idx_d  = '0;
               end else begin
                  idx_d   = '0;
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

endmodule

// File: tb/tb_y_axis_downsizer.sv
// Directed bench for y_axis_downsizer: a 4-beat instance driven against a lane
// scoreboard and a 1-beat instance acting as a register slice.
module tb_y_axis_downsizer;

   localparam int NB = 4;

   logic         clk = 1'b0;
   logic         rstn;

   logic [127:0] s_tdata;
   logic         s_tvalid, s_tlast, s_tready;
   logic [31:0]  m_tdata;
   logic [3:0]   m_tkeep;
   logic         m_tvalid, m_tlast, m_tready;
   logic [31:0]  bcnt;

   logic [31:0]  s1_tdata;
   logic         s1_tvalid, s1_tlast, s1_tready;
   logic [31:0]  m1_tdata;
   logic [3:0]   m1_tkeep;
   logic         m1_tvalid, m1_tlast, m1_tready;
   logic [31:0]  bcnt1;

   always #5 clk = ~clk;

   y_axis_downsizer #(.R(4), .WY(32), .AXI_WIDTH(32)) dut (
      .clk(clk), .rstn(rstn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .beat_count(bcnt)
   );

   y_axis_downsizer #(.R(1), .WY(32), .AXI_WIDTH(32)) dut1 (
      .clk(clk), .rstn(rstn),
      .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tlast(s1_tlast),
      .s_axis_tready(s1_tready),
      .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tvalid(m1_tvalid),
      .m_axis_tlast(m1_tlast), .m_axis_tready(m1_tready),
      .beat_count(bcnt1)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Source words, and the expected beat stream {tlast, data} derived from them.
   logic [127:0] wq[$];
   logic         lq[$];
   logic [32:0]  expq[$];
   int           in_lasts = 0;
   int           out_lasts = 0;

   // Bench view of the serialiser: word in flight and beat position within it.
   logic         busy = 1'b0;
   int           pos = 0;
   logic         stalled = 1'b0;
   logic [31:0]  held = '0;

   task automatic push_word(input logic [127:0] w, input logic l);
      wq.push_back(w);
      lq.push_back(l);
      if (l) in_lasts++;
      for (int i = 0; i < NB; i++)
         expq.push_back({(l && i == NB - 1), w[i*32 +: 32]});
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic run(input int ready_prob, input int max_beats);
      int          nb = 0;
      int          budget = 5000;
      logic [32:0] e;
      while (expq.size() > 0 && nb < max_beats) begin
         s_tvalid = (wq.size() > 0);
         s_tdata  = (wq.size() > 0) ? wq[0] : '0;
         s_tlast  = (lq.size() > 0) ? lq[0] : 1'b0;
         m_tready = (int'($urandom_range(99)) < ready_prob);
         #1;
         chk("tvalid", 64'(m_tvalid), 64'(busy));
         chk("s_tready", 64'(s_tready), 64'(!busy || (m_tready && pos == NB - 1)));
         chk("tkeep", 64'(m_tkeep), 64'h0F);
         if (stalled && m_tvalid) chk("stall_data", 64'(m_tdata), 64'(held));
         if (m_tvalid && m_tready) begin
            e = expq.pop_front();
            chk("beat_data", 64'(m_tdata), 64'(e[31:0]));
            chk("beat_last", 64'(m_tlast), 64'(e[32]));
            if (m_tlast) out_lasts++;
            nb++;
         end
         stalled = m_tvalid && !m_tready;
         held    = m_tdata;
         if (m_tvalid && m_tready) begin
            if (pos == NB - 1) begin busy = 1'b0; pos = 0; end
            else pos++;
         end
         if (s_tvalid && s_tready) begin
            busy = 1'b1;
            pos  = 0;
            void'(wq.pop_front());
            void'(lq.pop_front());
         end
         @(negedge clk);
         budget--;
         if (budget == 0) begin
            chk("timeout", 64'(0), 64'(1));
            break;
         end
      end
      s_tvalid = 1'b0;
   endtask

   logic [31:0] w1[5];
   logic        l1[5];

   initial begin
      rstn      = 1'b0;
      s_tdata   = '0; s_tvalid  = 1'b0; s_tlast  = 1'b0; m_tready  = 1'b1;
      s1_tdata  = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0; m1_tready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_tvalid", 64'(m_tvalid), 64'(0));
      chk("rst_s_tready", 64'(s_tready), 64'(0));
      chk("rst_tdata", 64'(m_tdata), 64'(0));
      chk("rst_tlast", 64'(m_tlast), 64'(0));
      chk("rst_tkeep", 64'(m_tkeep), 64'h0F);
      chk("rst_count", 64'(bcnt), 64'(0));
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("post_rst_s_tready", 64'(s_tready), 64'(1));
      @(negedge clk);

      // Single word, tlast on the top lane only.
      push_word(128'h44444444_33333333_22222222_11111111, 1'b1);
      run(100, 1000);
      chk("count_single", 64'(bcnt), 64'(4));

      // Three back-to-back words with tvalid held high.
      push_word(128'h0000000D_0000000C_0000000B_0000000A, 1'b0);
      push_word(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b0);
      push_word(128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A, 1'b1);
      run(100, 1000);
      chk("count_b2b", 64'(bcnt), 64'(16));

      // Random sink backpressure over 100 words.
      for (int i = 0; i < 100; i++)
         push_word({$urandom, $urandom, $urandom, $urandom}, ($urandom_range(3) == 0));
      run(50, 100000);
      chk("tlast_count", 64'(out_lasts), 64'(in_lasts));
      chk("count_bp", 64'(bcnt), 64'(416));

      // Reset after two beats of a word.
      push_word(128'h44444444_33333333_22222222_11111111, 1'b1);
      run(100, 2);
      rstn = 1'b0;
      #1;
      chk("midrst_tvalid", 64'(m_tvalid), 64'(0));
      chk("midrst_tdata", 64'(m_tdata), 64'(0));
      chk("midrst_tlast", 64'(m_tlast), 64'(0));
      chk("midrst_s_tready", 64'(s_tready), 64'(0));
      chk("midrst_count", 64'(bcnt), 64'(0));
      wq.delete(); lq.delete(); expq.delete();
      busy = 1'b0; pos = 0; stalled = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      m_tready = 1'b1;
      #1;
      chk("midrst_rel_s_tready", 64'(s_tready), 64'(1));
      @(negedge clk);
      push_word(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0);
      run(100, 1000);
      chk("count_after_rst", 64'(bcnt), 64'(4));

      // Counter wrap.
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.cnt_q;
      #1;
      chk("wrap_preload", 64'(bcnt), 64'hFFFF_FFFE);
      push_word(128'h87654321_0FEDCBA9_13579BDF_2468ACE0, 1'b1);
      run(100, 3);
      #1;
      chk("wrap_count", 64'(bcnt), 64'(1));
      run(100, 1000);
      chk("wrap_count_end", 64'(bcnt), 64'(2));

      // Single-beat instance as a register slice.
      w1 = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005};
      l1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      chk("nb1_count0", 64'(bcnt1), 64'(0));
      for (int k = 0; k <= 5; k++) begin
         s1_tvalid = (k < 5);
         s1_tdata  = w1[k % 5];
         s1_tlast  = l1[k % 5];
         m1_tready = 1'b1;
         #1;
         chk("nb1_s_tready", 64'(s1_tready), 64'(1));
         chk("nb1_tvalid", 64'(m1_tvalid), 64'(k > 0));
         if (k > 0) begin
            chk("nb1_data", 64'(m1_tdata), 64'(w1[k-1]));
            chk("nb1_last", 64'(m1_tlast), 64'(l1[k-1]));
         end
         @(negedge clk);
      end
      s1_tvalid = 1'b0;
      #1;
      chk("nb1_idle", 64'(m1_tvalid), 64'(0));
      chk("nb1_count", 64'(bcnt1), 64'(5));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
